pdh_frame_capture: RTL
======================

// Module: pdh_frame_capture
// PURPOSE
// Receive side of the core's frame-DMA handshake. Captures a fixed-length burst of
// 64-bit IQ/coefficient words from the core, buffers them in a FIFO, streams them
// out as an AXI4-Stream frame (tlast on the final beat) to the PS DMA engine, and
// reports engaged/finished status back to the core.
// PARAMETERS
// DATA_WIDTH  64    width of captured word and m_axis_tdata
// FRAME_LEN   2048  words per frame (>=2); tlast on word FRAME_LEN-1
// FIFO_DEPTH  16    buffer entries, power of 2, >=4
// DECIM       1     capture one word every DECIM clocks (>=1)
// PORTS
// clk             in   1           system clock
// rst_i           in   1           reset
// dma_enable_i    in   1           capture request level from core; rising edge starts frame
// dma_data_i      in   DATA_WIDTH  sample word from core, valid every cycle
// dma_engaged_o   out  1           frame in progress (CAPTURE or DRAIN)
// dma_finished_o  out  1           last frame fully streamed; sticky until next start
// overflow_o      out  1           sticky: a capture slot found the FIFO full
// m_axis_tdata    out  DATA_WIDTH  stream data
// m_axis_tvalid   out  1           stream valid
// m_axis_tready   in   1           stream ready from DMA
// m_axis_tlast    out  1           final beat of frame
// BEHAVIOUR
// - Reset: rst_i, asynchronous, active-high; clock clk. All outputs 0, FSM IDLE, FIFO empty,
//   counters 0, enable_d 0. Reset mid-frame drops the frame; tvalid falls immediately.
// - enable_d = dma_enable_i registered; start = dma_enable_i & ~enable_d.
// - FSM: IDLE -start-> CAPTURE (clear capture/beat/decim counters, finished, overflow).
//   CAPTURE -FRAME_LEN words pushed-> DRAIN. DRAIN -tlast beat accepted-> DONE.
//   DONE -> IDLE next cycle. start ignored outside IDLE.
// - dma_engaged_o = (CAPTURE|DRAIN), registered. dma_finished_o set on DONE entry,
//   held through IDLE, cleared at next start.
// - Capture: start seen at edge E; first slot at E+1, then every DECIM clocks
//   (decim counter 0..DECIM-1, reset at start). Each slot pushes dma_data_i if FIFO not full.
// - Full at a slot: word dropped, overflow_o<=1, capture counter NOT incremented, so the
//   frame still carries exactly FRAME_LEN words.
// - dma_enable_i falling during CAPTURE/DRAIN: ignored; frame always runs to completion.
// - FIFO: first-word-fall-through; ptrs log2(DEPTH)+1 bits; full = MSBs differ, low bits
//   equal; empty = ptrs equal. Push permitted only when !full (same-cycle pop does not
//   free a slot). Pop = tvalid & tready. Push into empty -> tvalid next cycle (E+2 min).
// - AXIS: tvalid = !empty; tdata/tlast stable while tvalid & !tready.
//   Beat counter counts accepted beats 0..FRAME_LEN-1; tlast = tvalid & (beat==FRAME_LEN-1).
//   Beat counter wraps to 0 on tlast accept.
// - Counters sized $clog2(FRAME_LEN)+1; no wrap within a frame.
// TESTING
// - Reset then FRAME_LEN=8, DECIM=1, tready=1, data=counter -> 8 beats 0..7 in order,
//   tlast only on 8th, engaged high E+1..tlast accept+1, finished high after, overflow 0.
// - tready=0 throughout CAPTURE, DEPTH=4, FRAME_LEN=8 -> overflow_o=1 after 5th slot;
//   release tready -> exactly 8 beats, tlast on 8th, finished=1.
// - Random tready (50%) with DECIM=3 -> words equal dma_data_i sampled at E+1,E+4,E+7..;
//   tdata/tlast never change while stalled.
// - Drop dma_enable_i 2 cycles after start, pulse again mid-frame -> frame completes once,
//   no restart; new start after DONE clears finished/overflow.
// - Assert rst_i mid-DRAIN with tvalid=1 -> tvalid, engaged, finished 0 asynchronously;
//   next start yields clean full frame.

Source files
------------

// File: rtl/pdh_frame_capture.sv
// ============================================================================
// Module   : pdh_frame_capture
// Purpose  : Captures a fixed-length burst of core words into a FWFT FIFO and
//            streams it out as one AXI4-Stream frame with tlast on the final beat.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pdh_frame_capture #(
    parameter int DATA_WIDTH = 64,
    parameter int FRAME_LEN  = 2048,
    parameter int FIFO_DEPTH = 16,
    parameter int DECIM      = 1
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  dma_enable_i,
    input  logic [DATA_WIDTH-1:0] dma_data_i,
    output logic                  dma_engaged_o,
    output logic                  dma_finished_o,
    output logic                  overflow_o,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam int CW  = $clog2(FRAME_LEN) + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  enable_q;
    logic                  engaged_q, engaged_d;
    logic                  finished_q, finished_d;
    logic                  overflow_q, overflow_d;
    logic [CW-1:0]         cap_cnt_q, cap_cnt_d;
    logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [DCW-1:0]        decim_q, decim_d;
    logic [AW:0]           wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic start, full, empty, slot, push, pop, last_beat;

    assign start     = dma_enable_i & ~enable_q;
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign slot      = (state_q == S_CAPTURE) && (decim_q == '0);
    assign push      = slot && !full;
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign last_beat = (beat_cnt_q == CW'(FRAME_LEN - 1));

    assign m_axis_tvalid  = !empty;
    assign m_axis_tdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign m_axis_tlast   = m_axis_tvalid && last_beat;
    assign dma_engaged_o  = engaged_q;
    assign dma_finished_o = finished_q;
    assign overflow_o     = overflow_q;

    always_comb begin
        state_d    = state_q;
        finished_d = finished_q;
        overflow_d = overflow_q;
        cap_cnt_d  = cap_cnt_q;
        decim_d    = decim_q;
        beat_cnt_d = beat_cnt_q;
        engaged_d  = (state_q == S_CAPTURE) || (state_q == S_DRAIN);

        if (pop) begin
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CAPTURE;
                    cap_cnt_d  = '0;
                    beat_cnt_d = '0;
                    decim_d    = '0;
                    finished_d = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            S_CAPTURE: begin
                decim_d = (decim_q == DCW'(DECIM - 1)) ? '0 : decim_q + 1'b1;
                // A dropped word does not advance the count, so the frame length is preserved.
                if (slot) begin
                    if (full) begin
                        overflow_d = 1'b1;
                    end else begin
                        cap_cnt_d = cap_cnt_q + 1'b1;
                        if (cap_cnt_q == CW'(FRAME_LEN - 1)) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (pop && last_beat) begin
                    state_d    = S_DONE;
                    finished_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            enable_q   <= 1'b0;
            engaged_q  <= 1'b0;
            finished_q <= 1'b0;
            overflow_q <= 1'b0;
            cap_cnt_q  <= '0;
            beat_cnt_q <= '0;
            decim_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            enable_q   <= dma_enable_i;
            engaged_q  <= engaged_d;
            finished_q <= finished_d;
            overflow_q <= overflow_d;
            cap_cnt_q  <= cap_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            decim_q    <= decim_d;
            wr_ptr_q   <= wr_ptr_q + {{AW{1'b0}}, push};
            rd_ptr_q   <= rd_ptr_q + {{AW{1'b0}}, pop};
        end
    end

    // Storage needs no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= dma_data_i;
        end
    end

endmodule

`default_nettype wire
